// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line fill on miss.
// Optional performance counters are enabled with ICACHE_PERF_EN.
module icache_dm #(
  parameter int unsigned NUM_SETS  = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic [31:0]          mem_address,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic [31:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]          perf_hit_count,
  output logic [31:0]          perf_miss_count
`endif
);

  localparam int unsigned OFF_W = 5;
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;

  if (LINE_BITS != 256) begin : g_bad_line_bits
    $error("icache_dm: LINE_BITS must be 256");
  end
  if ((NUM_SETS < 2) || ((NUM_SETS & (NUM_SETS - 1)) != 0)) begin : g_bad_num_sets
    $error("icache_dm: NUM_SETS must be a power of two >= 2");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            fill_addr_q, fill_addr_d;
  logic [NUM_SETS-1:0]    valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0]   data_q [NUM_SETS];

  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [2:0]             req_word;
  logic [IDX_W-1:0]       fill_idx;
  logic [TAG_W-1:0]       fill_tag;
  logic                   hit;
  logic                   install;
  logic                   miss_start;
  logic                   unused_addr_bits;

  assign req_idx  = mem_address[OFF_W +: IDX_W];
  assign req_tag  = mem_address[31 -: TAG_W];
  assign req_word = mem_address[4:2];
  assign fill_idx = fill_addr_q[OFF_W +: IDX_W];
  assign fill_tag = fill_addr_q[31 -: TAG_W];
  assign unused_addr_bits = ^mem_address[1:0];

  assign hit          = mem_read && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign pmem_address = fill_addr_q;

  // Hit check and response in IDLE; FILL holds the request until the line returns.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    mem_resp    = 1'b0;
    mem_rdata   = 32'd0;
    pmem_read   = 1'b0;
    install     = 1'b0;
    miss_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_resp = hit;
        if (hit) begin
          mem_rdata = data_q[req_idx][{req_word, 5'd0} +: 32];
        end else if (mem_read) begin
          fill_addr_d = {mem_address[31:OFF_W], 5'd0};
          state_d     = S_FILL;
          miss_start  = 1'b1;
        end
      end
      S_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          install = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fill_addr_q <= 32'd0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      if (install) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= pmem_rdata;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_q  <= 32'd0;
      perf_miss_q <= 32'd0;
    end else begin
      if (mem_resp && (perf_hit_q != 32'hFFFF_FFFF)) begin
        perf_hit_q <= perf_hit_q + 32'd1;
      end
      if (miss_start && (perf_miss_q != 32'hFFFF_FFFF)) begin
        perf_miss_q <= perf_miss_q + 32'd1;
      end
    end
  end

  assign perf_hit_count  = perf_hit_q;
  assign perf_miss_count = perf_miss_q;
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomized self-checking bench for icache_dm against a line-address cache model.
module tb_icache_dm;

  localparam int NUM_SETS = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef ICACHE_PERF_EN
  logic [31:0]  perf_hit_count;
  logic [31:0]  perf_miss_count;
`endif

  int total = 0;
  int bad   = 0;

  bit          mvalid [NUM_SETS];
  logic [31:0] mline  [NUM_SETS];

  icache_dm #(.NUM_SETS(NUM_SETS), .LINE_BITS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit_count  (perf_hit_count),
    .perf_miss_count (perf_miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Backing memory contents: a hash of the word address, with one fixed word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w == 32'h0000_006C) return 32'h0000_0013;
    return (w * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = a & ~32'h1F;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(base + 32'(4 * w));
    return l;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / 32) % NUM_SETS);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[set_of(a)] && (mline[set_of(a)] == (a & ~32'h1F));
  endfunction

  function automatic void model_install(input logic [31:0] a);
    mvalid[set_of(a)] = 1'b1;
    mline[set_of(a)]  = a & ~32'h1F;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NUM_SETS; s++) mvalid[s] = 1'b0;
  endfunction

  // Issues one fetch and plays the memory side; reports what the DUT did.
  task automatic do_fetch(input logic [31:0] addr, input int lat,
                          output bit to, output int cyc, output logic [31:0] rdata,
                          output logic [31:0] fa, output bit stable, output int nfill,
                          output bit pr0);
    to = 1'b1; cyc = -1; rdata = '0; fa = '0; stable = 1'b1; nfill = 0; pr0 = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = addr; pmem_resp = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) pr0 = pmem_read;
      if (mem_resp) begin
        to = 1'b0; cyc = c; rdata = mem_rdata;
        break;
      end
      if (c > 0) begin
        if (pmem_read) nfill++; else stable = 1'b0;
        if (c == 1) fa = pmem_address;
        else if (pmem_address !== fa) stable = 1'b0;
      end
      @(posedge clk); #1;
      pmem_resp  = (c == lat);
      pmem_rdata = line_of(pmem_address);
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b0; mem_address = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 mem_read = 1'b1; mem_address = 32'h60;
    @(negedge clk);
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
    total++; if (pmem_address !== 32'd0) begin bad++; $display("FAIL reset_pmem_address got=%h exp=0", pmem_address); end
    total++; if (mem_resp !== 1'b0) begin bad++; $display("FAIL reset_mem_resp got=%b exp=0", mem_resp); end
    total++; if (mem_rdata !== 32'd0) begin bad++; $display("FAIL reset_mem_rdata got=%h exp=0", mem_rdata); end
    @(posedge clk); #1 rst = 1'b0; mem_read = 1'b0;
  endtask

  task automatic test_cold_miss();
    bit to, st, pr0; int cyc, nf; logic [31:0] rd, fa;
    do_fetch(32'h60, 2, to, cyc, rd, fa, st, nf, pr0);
    model_install(32'h60);
    total++; if (to) begin bad++; $display("FAIL cold_timeout got=no_resp exp=resp"); end
    total++; if (cyc !== 4) begin bad++; $display("FAIL cold_penalty got=%0d exp=4", cyc); end
    total++; if (fa !== 32'h60) begin bad++; $display("FAIL cold_pmem_address got=%h exp=00000060", fa); end
    total++; if (nf !== 3 || !st) begin bad++; $display("FAIL cold_fill_hold got=%0d/%0b exp=3/1", nf, st); end
    total++; if (rd !== mem_word(32'h60)) begin bad++; $display("FAIL cold_rdata got=%h exp=%h", rd, mem_word(32'h60)); end
  endtask

  task automatic test_back_to_back();
    bit to, st, pr0; int cyc, nf; logic [31:0] rd, fa, a;
    for (int i = 0; i < 4; i++) begin
      a = 32'h60 + 32'(4 * i);
      do_fetch(a, 1, to, cyc, rd, fa, st, nf, pr0);
      total++; if (cyc !== 0 || pr0 !== 1'b0) begin bad++; $display("FAIL b2b_hit addr=%h got=cyc%0d/pr%0b exp=cyc0/pr0", a, cyc, pr0); end
      total++; if (rd !== mem_word(a)) begin bad++; $display("FAIL b2b_rdata addr=%h got=%h exp=%h", a, rd, mem_word(a)); end
    end
    total++; if (rd !== 32'h0000_0013) begin bad++; $display("FAIL b2b_word3 got=%h exp=00000013", rd); end
  endtask

  task automatic test_conflict();
    bit to, st, pr0; int cyc, nf; logic [31:0] rd, fa;
    do_fetch(32'h260, 1, to, cyc, rd, fa, st, nf, pr0);
    model_install(32'h260);
    total++; if (cyc !== 3 || fa !== 32'h260) begin bad++; $display("FAIL conflict_fill1 got=cyc%0d/%h exp=cyc3/00000260", cyc, fa); end
    total++; if (rd !== mem_word(32'h260)) begin bad++; $display("FAIL conflict_rdata1 got=%h exp=%h", rd, mem_word(32'h260)); end
    do_fetch(32'h60, 0, to, cyc, rd, fa, st, nf, pr0);
    model_install(32'h60);
    total++; if (cyc !== 2 || fa !== 32'h60) begin bad++; $display("FAIL conflict_fill2 got=cyc%0d/%h exp=cyc2/00000060", cyc, fa); end
    total++; if (rd !== mem_word(32'h60)) begin bad++; $display("FAIL conflict_rdata2 got=%h exp=%h", rd, mem_word(32'h60)); end
  endtask

  task automatic test_addr_change();
    bit to, st, pr0; int cyc, nf; logic [31:0] rd, fa;
    @(posedge clk); #1 mem_read = 1'b1; mem_address = 32'h100;
    @(negedge clk);
    total++; if (mem_resp !== 1'b0) begin bad++; $display("FAIL chg_miss got=%b exp=0", mem_resp); end
    @(posedge clk); #1 mem_address = 32'h104; mem_read = 1'b0;
    @(negedge clk);
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h100) begin bad++; $display("FAIL chg_fill1 got=%b/%h exp=1/00000100", pmem_read, pmem_address); end
    @(posedge clk); #1 mem_read = 1'b1; pmem_resp = 1'b1; pmem_rdata = line_of(pmem_address);
    @(negedge clk);
    total++; if (pmem_address !== 32'h100 || mem_resp !== 1'b0) begin bad++; $display("FAIL chg_fill2 got=%h/%b exp=00000100/0", pmem_address, mem_resp); end
    @(posedge clk); #1 pmem_resp = 1'b0;
    model_install(32'h100);
    @(negedge clk);
    total++; if (mem_resp !== 1'b1 || mem_rdata !== mem_word(32'h104)) begin bad++; $display("FAIL chg_hit got=%b/%h exp=1/%h", mem_resp, mem_rdata, mem_word(32'h104)); end
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL chg_pmem_idle got=%b exp=0", pmem_read); end
    do_fetch(32'h104, 1, to, cyc, rd, fa, st, nf, pr0);
    total++; if (cyc !== 0) begin bad++; $display("FAIL chg_refetch got=cyc%0d exp=cyc0", cyc); end
  endtask

  task automatic test_reset_mid_fill();
    bit to, st, pr0; int cyc, nf; logic [31:0] rd, fa;
    @(posedge clk); #1 mem_read = 1'b1; mem_address = 32'h400;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h400) begin bad++; $display("FAIL rstfill_active got=%b/%h exp=1/00000400", pmem_read, pmem_address); end
    @(posedge clk); #1 rst = 1'b1; mem_read = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL rstfill_async got=%b exp=0", pmem_read); end
    model_clear();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 pmem_resp = 1'b1; pmem_rdata = line_of(32'h400);
    @(negedge clk);
    total++; if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin bad++; $display("FAIL rstfill_late_resp got=%b/%b exp=0/0", pmem_read, mem_resp); end
    @(posedge clk); #1 pmem_resp = 1'b0;
    do_fetch(32'h400, 1, to, cyc, rd, fa, st, nf, pr0);
    model_install(32'h400);
    total++; if (cyc !== 3 || fa !== 32'h400) begin bad++; $display("FAIL rstfill_remiss got=cyc%0d/%h exp=cyc3/00000400", cyc, fa); end
    total++; if (rd !== mem_word(32'h400)) begin bad++; $display("FAIL rstfill_rdata got=%h exp=%h", rd, mem_word(32'h400)); end
  endtask

  task automatic test_random();
    bit to, st, pr0, eh; int cyc, nf, lat; logic [31:0] rd, fa, a, tg;
    logic [31:0] tags [4];
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2A5A5; tags[3] = 32'h7FFFFF;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1 mem_read = 1'b0; mem_address = $urandom;
        @(negedge clk);
        total++; if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin bad++; $display("FAIL rnd_idle got=%b/%b exp=0/0", mem_resp, pmem_read); end
      end
      tg  = tags[$urandom_range(0, 3)];
      a   = (tg << 9) | (32'($urandom_range(0, 5)) << 5) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      lat = $urandom_range(0, 3);
      eh  = model_hit(a);
      do_fetch(a, lat, to, cyc, rd, fa, st, nf, pr0);
      if (!eh) model_install(a);
      total++; if (to || rd !== mem_word(a)) begin bad++; $display("FAIL rnd_rdata addr=%h got=%h exp=%h", a, rd, mem_word(a)); end
      total++; if (cyc !== (eh ? 0 : lat + 2)) begin bad++; $display("FAIL rnd_latency addr=%h got=%0d exp=%0d", a, cyc, eh ? 0 : lat + 2); end
      total++; if (pr0 !== 1'b0) begin bad++; $display("FAIL rnd_pmem_first addr=%h got=%b exp=0", a, pr0); end
      if (!eh) begin
        total++; if (fa !== (a & ~32'h1F) || !st || nf !== lat + 1) begin bad++; $display("FAIL rnd_fill addr=%h got=%h/%0b/%0d exp=%h/1/%0d", a, fa, st, nf, a & ~32'h1F, lat + 1); end
      end
    end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    bit to, st, pr0; int cyc, nf; logic [31:0] rd, fa;
    @(posedge clk); #1 rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    total++; if (perf_hit_count !== 32'd0 || perf_miss_count !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_hit_count, perf_miss_count); end
    do_fetch(32'h700, 1, to, cyc, rd, fa, st, nf, pr0);
    for (int i = 1; i < 5; i++) do_fetch(32'h700 + 32'(4 * i), 0, to, cyc, rd, fa, st, nf, pr0);
    @(posedge clk); #1 mem_read = 1'b0;
    @(negedge clk);
    total++; if (perf_hit_count !== 32'd5) begin bad++; $display("FAIL perf_hits got=%0d exp=5", perf_hit_count); end
    total++; if (perf_miss_count !== 32'd1) begin bad++; $display("FAIL perf_misses got=%0d exp=1", perf_miss_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_addr_change();
    test_reset_mid_fill();
    test_random();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
